ldpc_sys_encoder: RTL and testbench

//  Systematic LDPC encoder; transmit-side counterpart of the IAMS min-sum decoder.

---
 rtl/ldpc_sys_encoder_if.sv | 27 ++
 rtl/ldpc_sys_encoder.sv | 169 ++++++++++++++++
 tb/tb_ldpc_sys_encoder.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ldpc_sys_encoder_if.sv
// ldpc_sys_encoder_if: message-in / codeword-out stream bundle of the systematic LDPC encoder.
//   Message stream : msg_bit, msg_valid (to encoder), msg_ready (from encoder)
//   Codeword stream: cw_data[OUT_W], cw_valid, cw_last (from encoder), cw_ready (to encoder)
// Modports:
//   master : the environment side (produces message bits, consumes the codeword)
//   slave  : the encoder side
interface ldpc_sys_encoder_if #(
  parameter int unsigned OUT_W = 1
);
  logic             msg_bit;
  logic             msg_valid;
  logic             msg_ready;
  logic [OUT_W-1:0] cw_data;
  logic             cw_valid;
  logic             cw_ready;
  logic             cw_last;

  modport master (
    output msg_bit, msg_valid, cw_ready,
    input  msg_ready, cw_data, cw_valid, cw_last
  );

  modport slave (
    input  msg_bit, msg_valid, cw_ready,
    output msg_ready, cw_data, cw_valid, cw_last
  );
endinterface

// File: rtl/ldpc_sys_encoder.sv
// ldpc_sys_encoder: systematic LDPC encoder for H = [P^T | I_M].
// Accepts K message bits serially, accumulates the M = N-K parity bits as they
// arrive, then streams the N-bit codeword c = {u[0..K-1], p[0..M-1]}.
// Ports:
//   clk          clock
//   rst          synchronous active-high reset
//   bus          ldpc_sys_encoder_if.slave (msg_bit/msg_valid/msg_ready,
//                cw_data/cw_valid/cw_ready/cw_last)
//   busy         high whenever state != LOAD or the bit counter != 0
//   frame_count  completed frames, wraps at 16'hFFFF
// Build option:
//   OUTPUT_LLR_EN  when defined, cw_data is a signed LLR_WIDTH value
//                  (bit 0 -> +LLR_MAG, bit 1 -> -LLR_MAG); otherwise the hard bit.
module ldpc_sys_encoder #(
  parameter int unsigned             K         = 4,
  parameter int unsigned             N         = 8,
  parameter logic [K*(N-K)-1:0]      P_MATRIX  = 16'hEDB7,
  parameter int unsigned             LLR_WIDTH = 4,
  parameter int                      LLR_MAG   = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  ldpc_sys_encoder_if.slave    bus,
  output logic                 busy,
  output logic [15:0]          frame_count
);

  localparam int unsigned M     = N - K;
  localparam int unsigned CNT_W = $clog2(N) + 1;
`ifdef OUTPUT_LLR_EN
  localparam int unsigned OUT_W = LLR_WIDTH;
  localparam logic [OUT_W-1:0] LLR_POS = OUT_W'(LLR_MAG);
  localparam logic [OUT_W-1:0] LLR_NEG = OUT_W'(-LLR_MAG);
`else
  localparam int unsigned OUT_W = 1;
`endif

  // Reject parameter sets that cannot form a valid code or LLR encoding
  if (K < 1 || N <= K || LLR_WIDTH < 2 || LLR_MAG < 1 ||
      LLR_MAG >= (1 << (LLR_WIDTH - 1))) begin : g_param_check
    $error("ldpc_sys_encoder: illegal parameter combination");
  end

  typedef enum logic [0:0] {
    LOAD = 1'b0,
    EMIT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;          // k in LOAD, codeword index in EMIT
  logic [K-1:0]     msg_q, msg_d;
  logic [M-1:0]     parity_q, parity_d;
  logic             msg_ready_q, msg_ready_d;
  logic             cw_valid_q, cw_valid_d;
  logic             cw_last_q, cw_last_d;
  logic [OUT_W-1:0] cw_data_q, cw_data_d;
  logic             busy_q, busy_d;
  logic [15:0]      frame_count_q, frame_count_d;

  logic [M-1:0]     p_row;                 // row k of P: parity bits touched by u[k]
  logic [N-1:0]     cw_vec;                // codeword as stored, bit i = c[i]
  logic [N-1:0]     cw_sh;

  // Map a codeword bit onto the output symbol format
  function automatic logic [OUT_W-1:0] to_sym(input logic b);
`ifdef OUTPUT_LLR_EN
    return b ? LLR_NEG : LLR_POS;
`else
    return b;
`endif
  endfunction

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= LOAD;
      cnt_q         <= '0;
      msg_q         <= '0;
      parity_q      <= '0;
      msg_ready_q   <= 1'b1;
      cw_valid_q    <= 1'b0;
      cw_last_q     <= 1'b0;
      cw_data_q     <= '0;
      busy_q        <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      msg_q         <= msg_d;
      parity_q      <= parity_d;
      msg_ready_q   <= msg_ready_d;
      cw_valid_q    <= cw_valid_d;
      cw_last_q     <= cw_last_d;
      cw_data_q     <= cw_data_d;
      busy_q        <= busy_d;
      frame_count_q <= frame_count_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    msg_d         = msg_q;
    parity_d      = parity_q;
    msg_ready_d   = msg_ready_q;
    cw_valid_d    = cw_valid_q;
    cw_last_d     = cw_last_q;
    cw_data_d     = cw_data_q;
    frame_count_d = frame_count_q;
    cw_sh         = '0;
    p_row         = M'(P_MATRIX >> (cnt_q * M));
    cw_vec        = {parity_q, msg_q};

    case (state_q)
      LOAD: begin
        if (bus.msg_valid && msg_ready_q) begin
          msg_d    = (msg_q & ~(K'(1) << cnt_q)) | (K'(bus.msg_bit) << cnt_q);
          parity_d = parity_q ^ (p_row & {M{bus.msg_bit}});
          if (cnt_q == CNT_W'(K - 1)) begin
            // Last message bit: first codeword symbol (u[0]) goes out next cycle
            cnt_d       = '0;
            state_d     = EMIT;
            msg_ready_d = 1'b0;
            cw_valid_d  = 1'b1;
            cw_last_d   = 1'b0;
            cw_data_d   = to_sym(msg_d[0]);
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      EMIT: begin
        if (cw_valid_q && bus.cw_ready) begin
          if (cnt_q == CNT_W'(N - 1)) begin
            state_d       = LOAD;
            cnt_d         = '0;
            parity_d      = '0;
            frame_count_d = frame_count_q + 16'd1;
            msg_ready_d   = 1'b1;
            cw_valid_d    = 1'b0;
            cw_last_d     = 1'b0;
            cw_data_d     = '0;
          end else begin
            cnt_d     = cnt_q + CNT_W'(1);
            cw_sh     = cw_vec >> cnt_d;
            cw_data_d = to_sym(cw_sh[0]);
            cw_last_d = (cnt_d == CNT_W'(N - 1));
          end
        end
      end

      default: begin
        state_d = LOAD;
      end
    endcase

    busy_d = (state_d != LOAD) || (cnt_d != '0);
  end

  assign bus.msg_ready = msg_ready_q;
  assign bus.cw_valid  = cw_valid_q;
  assign bus.cw_last   = cw_last_q;
  assign bus.cw_data   = cw_data_q;
  assign busy          = busy_q;
  assign frame_count   = frame_count_q;

endmodule

// File: tb/tb_ldpc_sys_encoder.sv
// tb_ldpc_sys_encoder: self-checking bench for ldpc_sys_encoder (K=4, N=8, P=16'hEDB7).
// Expected codeword symbols are queued when a message is sent and popped as the
// encoder emits them. Works with or without OUTPUT_LLR_EN.
module tb_ldpc_sys_encoder;

  localparam int unsigned K = 4;
  localparam int unsigned N = 8;
  localparam int unsigned M = N - K;
  localparam logic [K*M-1:0] P = 16'hEDB7;
`ifdef OUTPUT_LLR_EN
  localparam int unsigned OUT_W = 4;
`else
  localparam int unsigned OUT_W = 1;
`endif

  typedef struct packed {
    logic [OUT_W-1:0] d;
    logic             last;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        busy;
  logic [15:0] frame_count;

  int    total = 0;
  int    bad   = 0;
  int    fc_exp = 0;
  beat_t exp_q[$];

  ldpc_sys_encoder_if #(.OUT_W(OUT_W)) bus();

  ldpc_sys_encoder #(
    .K(K), .N(N), .P_MATRIX(P), .LLR_WIDTH(4), .LLR_MAG(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .busy(busy),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  // Expected output symbol for a codeword bit
  function automatic logic [OUT_W-1:0] sym(input logic b);
`ifdef OUTPUT_LLR_EN
    return b ? 4'hD : 4'h3;
`else
    return b;
`endif
  endfunction

  // Hard bit recovered from an output symbol
  function automatic logic bit_of(input logic [OUT_W-1:0] d);
    return d[OUT_W-1];
  endfunction

  // Reference encoder: c = {u, p}, p[m] = XOR_k u[k] & P[k*M+m]
  function automatic logic [N-1:0] model_cw(input logic [K-1:0] u);
    logic [N-1:0] c;
    logic p;
    c = '0;
    for (int k = 0; k < K; k++) c[k] = u[k];
    for (int m = 0; m < M; m++) begin
      p = 1'b0;
      for (int k = 0; k < K; k++) p = p ^ (u[k] & P[k*M+m]);
      c[K+m] = p;
    end
    return c;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    fc_exp = 0;
    exp_q.delete();
  endtask

  // Send one message (optionally with random idle gaps) and queue its codeword
  task automatic send_frame(input logic [K-1:0] u, input logic [N-1:0] cw, input bit gaps);
    int w;
    beat_t b;
    for (int i = 0; i < N; i++) begin
      b.d    = sym(cw[i]);
      b.last = (i == N - 1);
      exp_q.push_back(b);
    end
    for (int k = 0; k < K; k++) begin
      if (gaps && ($urandom_range(0, 1) == 1)) begin
        bus.msg_valid = 1'b0;
        bus.msg_bit   = 1'b1;
        @(negedge clk);
      end
      bus.msg_bit   = u[k];
      bus.msg_valid = 1'b1;
      w = 0;
      while (bus.msg_ready !== 1'b1 && w < 20) begin
        @(negedge clk);
        w++;
      end
      total++;
      if (w >= 20) begin
        bad++;
        $display("FAIL msg_ready_timeout: got %0b want 1", bus.msg_ready);
      end
      @(negedge clk);
    end
    bus.msg_valid = 1'b0;
    // Codeword must start exactly one cycle after the last accept
    total++;
    if (bus.cw_valid !== 1'b1) begin
      bad++;
      $display("FAIL first_valid_latency: got %0b want 1", bus.cw_valid);
    end
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL busy_emit: got %0b want 1", busy);
    end
  endtask

  // Collect one codeword, stalling stall_len cycles on beat stall_beat
  task automatic recv_frame(input int stall_beat, input int stall_len);
    int b = 0;
    int stalls = 0;
    int guard = 0;
    logic [N-1:0] rx = '0;
    logic s;
    beat_t e;
    while (b < N && guard < 200) begin
      guard++;
      total++;
      if (bus.cw_valid !== 1'b1) begin
        bad++;
        $display("FAIL cw_valid_emit beat %0d: got %0b want 1", b, bus.cw_valid);
      end
      total++;
      if (bus.msg_ready !== 1'b0) begin
        bad++;
        $display("FAIL msg_ready_emit beat %0d: got %0b want 0", b, bus.msg_ready);
      end
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL scoreboard_empty beat %0d: got 0 entries want 1", b);
        b = N;
      end else if (b == stall_beat && stalls < stall_len) begin
        bus.cw_ready = 1'b0;
        stalls++;
        total++;
        if (bus.cw_data !== exp_q[0].d) begin
          bad++;
          $display("FAIL stall_data beat %0d: got %0h want %0h", b, bus.cw_data, exp_q[0].d);
        end
      end else begin
        bus.cw_ready = 1'b1;
        e = exp_q.pop_front();
        total++;
        if (bus.cw_data !== e.d) begin
          bad++;
          $display("FAIL cw_data beat %0d: got %0h want %0h", b, bus.cw_data, e.d);
        end
        total++;
        if (bus.cw_last !== e.last) begin
          bad++;
          $display("FAIL cw_last beat %0d: got %0b want %0b", b, bus.cw_last, e.last);
        end
        rx[b] = bit_of(bus.cw_data);
        b++;
      end
      @(negedge clk);
    end
    bus.cw_ready = 1'b0;
    total++;
    if (guard >= 200) begin
      bad++;
      $display("FAIL recv_timeout: got %0d beats want %0d", b, N);
    end
    fc_exp = (fc_exp + 1) % 65536;
    total++;
    if (bus.cw_valid !== 1'b0 || bus.cw_last !== 1'b0) begin
      bad++;
      $display("FAIL end_of_frame_valid: got valid=%0b last=%0b want 0 0", bus.cw_valid, bus.cw_last);
    end
    total++;
    if (bus.msg_ready !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL end_of_frame_ready: got ready=%0b busy=%0b want 1 0", bus.msg_ready, busy);
    end
    total++;
    if (frame_count !== 16'(fc_exp)) begin
      bad++;
      $display("FAIL frame_count: got %0d want %0d", frame_count, fc_exp);
    end
    // Parity-check equations H*c^T = 0 on what was actually received
    for (int m = 0; m < M; m++) begin
      s = rx[K+m];
      for (int k = 0; k < K; k++) s = s ^ (rx[k] & P[k*M+m]);
      total++;
      if (s !== 1'b0) begin
        bad++;
        $display("FAIL syndrome row %0d: got %0b want 0 (cw %0h)", m, s, rx);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (bus.msg_ready !== 1'b1 || bus.cw_valid !== 1'b0 || bus.cw_last !== 1'b0 ||
        bus.cw_data !== '0 || busy !== 1'b0 || frame_count !== 16'd0) begin
      bad++;
      $display("FAIL reset_state: got ready=%0b valid=%0b last=%0b data=%0h busy=%0b fc=%0d want 1 0 0 0 0 0",
               bus.msg_ready, bus.cw_valid, bus.cw_last, bus.cw_data, busy, frame_count);
    end
    rst = 1'b0;
    fc_exp = 0;
    exp_q.delete();
    @(negedge clk);
  endtask

  task automatic test_vectors();
    send_frame(4'b0000, 8'h00, 1'b0);
    recv_frame(-1, 0);
    send_frame(4'b0001, 8'h71, 1'b0);
    recv_frame(-1, 0);
    send_frame(4'b0011, 8'hC3, 1'b0);
    recv_frame(-1, 0);
    send_frame(4'b1111, 8'hFF, 1'b0);
    recv_frame(-1, 0);
  endtask

  task automatic test_backpressure();
    send_frame(4'b0001, 8'h71, 1'b0);
    recv_frame(2, 3);
  endtask

  task automatic test_msg_gaps();
    send_frame(4'b0011, 8'hC3, 1'b1);
    recv_frame(-1, 0);
    send_frame(4'b0001, 8'h71, 1'b1);
    recv_frame(5, 1);
  endtask

  task automatic test_rst_load();
    bus.msg_bit   = 1'b1;
    bus.msg_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus.msg_valid = 1'b0;
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL busy_partial_load: got %0b want 1", busy);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    fc_exp = 0;
    total++;
    if (busy !== 1'b0 || bus.msg_ready !== 1'b1 || frame_count !== 16'd0) begin
      bad++;
      $display("FAIL rst_load_state: got busy=%0b ready=%0b fc=%0d want 0 1 0",
               busy, bus.msg_ready, frame_count);
    end
    send_frame(4'b0001, 8'h71, 1'b0);
    recv_frame(-1, 0);
  endtask

  task automatic test_rst_emit();
    send_frame(4'b1111, 8'hFF, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    fc_exp = 0;
    total++;
    if (bus.cw_valid !== 1'b0 || bus.msg_ready !== 1'b1 || busy !== 1'b0 || frame_count !== 16'd0) begin
      bad++;
      $display("FAIL rst_emit_state: got valid=%0b ready=%0b busy=%0b fc=%0d want 0 1 0 0",
               bus.cw_valid, bus.msg_ready, busy, frame_count);
    end
    send_frame(4'b0011, 8'hC3, 1'b0);
    recv_frame(-1, 0);
  endtask

  task automatic test_back_to_back();
    logic [K-1:0] u;
    do_reset();
    for (int f = 0; f < 1000; f++) begin
      u = K'($urandom_range(0, (1 << K) - 1));
      send_frame(u, model_cw(u), (f % 3) == 0);
      recv_frame(int'($urandom_range(0, N - 1)), int'($urandom_range(0, 2)));
    end
    total++;
    if (frame_count !== 16'd1000) begin
      bad++;
      $display("FAIL frame_count_1000: got %0d want 1000", frame_count);
    end
  endtask

  initial begin
    rst           = 1'b1;
    bus.msg_bit   = 1'b0;
    bus.msg_valid = 1'b0;
    bus.cw_ready  = 1'b0;
    @(negedge clk);
    test_reset();
    test_vectors();
    test_backpressure();
    test_msg_gaps();
    test_rst_load();
    test_rst_emit();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
